// File: rtl/rx_frame_checker.sv
// rx_frame_checker: hunts for framed sample streams on a 16-bit transceiver
// lane, emits samples and timestamps, and reports good/aborted frames.
module rx_frame_checker #(
  parameter int          FRAME_LEN  = 128,
  parameter logic [15:0] START_WORD = 16'hDEAD,
  parameter logic [15:0] END_WORD   = 16'h7FFF
) (
  input  logic        rx_std_clkout,
  input  logic        rst,
  input  logic [1:0]  rx_syncstatus,
  input  logic [1:0]  rx_datak,
  input  logic [15:0] RX_data,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] frame_ts,
  output logic        ts_valid,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic [15:0] err_count,
  output logic        link_up
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 4);

  typedef enum logic [1:0] {
    HUNT,
    TS,
    DATA,
    ENDCHK
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   data_q;
  logic          valid_q;
  logic          sof_q;
  logic          eof_q;
  logic [15:0]   ts_q;
  logic          ts_valid_q;
  logic          ok_q;
  logic          err_q;
  logic [15:0]   frame_count_q;
  logic [15:0]   err_count_q;
  logic          link_q;

  logic          link_ok;
  logic [15:0]   frame_count_d;
  logic [15:0]   err_count_d;

  // Lane is usable only with both bytes in sync and no control characters.
  assign link_ok = (rx_syncstatus == 2'b11) && (rx_datak == 2'b00);

  // Saturating next values for the two frame counters.
  always_comb begin
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
    if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  // Frame FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge rx_std_clkout) begin
    if (rst) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      ts_q          <= '0;
      ts_valid_q    <= 1'b0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
      link_q        <= 1'b0;
    end else begin
      link_q     <= link_ok;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ts_valid_q <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        HUNT: begin
          if (link_ok && RX_data == START_WORD) state_q <= TS;
        end
        TS: begin
          if (!link_ok) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_d;
            state_q     <= HUNT;
          end else begin
            ts_q       <= RX_data;
            ts_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (!link_ok) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_d;
            state_q     <= HUNT;
          end else begin
            data_q  <= RX_data;
            valid_q <= 1'b1;
            sof_q   <= (cnt_q == '0);
            eof_q   <= (cnt_q == LAST);
            if (cnt_q == LAST) state_q <= ENDCHK;
            else cnt_q <= cnt_q + 1'b1;
          end
        end
        ENDCHK: begin
          if (!link_ok) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_d;
            state_q     <= HUNT;
          end else if (RX_data == END_WORD) begin
            ok_q          <= 1'b1;
            frame_count_q <= frame_count_d;
            state_q       <= HUNT;
          end else begin
            // A start marker in the end slot resyncs straight onto a new frame.
            err_q       <= 1'b1;
            err_count_q <= err_count_d;
            state_q     <= (RX_data == START_WORD) ? TS : HUNT;
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_sof     = sof_q;
  assign out_eof     = eof_q;
  assign frame_ts    = ts_q;
  assign ts_valid    = ts_valid_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
  assign link_up     = link_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: vector table plus frame-level sequences; every driven
// word queues its expected next-cycle outputs, popped once the DUT responds.
module tb_rx_frame_checker;

  localparam logic [15:0] SW = 16'hDEAD;
  localparam logic [15:0] EW = 16'h7FFF;

  logic        clk;
  logic        rst;
  logic [1:0]  sync;
  logic [1:0]  datak;
  logic [15:0] rxd;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] frame_ts;
  logic        ts_valid;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic        link_up;

  rx_frame_checker dut (
    .rx_std_clkout (clk),
    .rst           (rst),
    .rx_syncstatus (sync),
    .rx_datak      (datak),
    .RX_data       (rxd),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .frame_ts      (frame_ts),
    .ts_valid      (ts_valid),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .frame_count   (frame_count),
    .err_count     (err_count),
    .link_up       (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        tsv;
    logic [15:0] ts;
    logic        ok;
    logic        err;
    logic        link;
  } exp_t;

  typedef struct {
    logic [1:0]  sy;
    logic [1:0]  dk;
    logic [15:0] w;
    logic        tsv;
    logic [15:0] ts;
    logic        err;
  } vec_t;

  exp_t  sbq[$];
  int    total;
  int    bad;
  int    vcount;
  int    okcount;
  string tag;

  function automatic exp_t none();
    return '0;
  endfunction

  function automatic exp_t mk_ts(logic [15:0] t);
    exp_t e = '0;
    e.tsv = 1'b1;
    e.ts  = t;
    return e;
  endfunction

  function automatic exp_t mk_s(int i, logic [15:0] v);
    exp_t e = '0;
    e.valid = 1'b1;
    e.data  = v;
    e.sof   = (i == 0);
    e.eof   = (i == 124);
    return e;
  endfunction

  function automatic exp_t mk_end(logic good);
    exp_t e = '0;
    e.ok  = good;
    e.err = !good;
    return e;
  endfunction

  task automatic check16(string name, logic [15:0] got, logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // One cycle: drive at negedge, queue expectation, compare after posedge.
  task automatic drive(input logic [15:0] w, input logic [1:0] sy,
                       input logic [1:0] dk, input logic r,
                       input exp_t e);
    exp_t x;
    exp_t g;
    @(negedge clk);
    rst   = r;
    rxd   = w;
    sync  = sy;
    datak = dk;
    e.link = !r && sy == 2'b11 && dk == 2'b00;
    if (r) e = '0;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    if (!x.valid) x.data = '0;
    if (!x.tsv) x.ts = '0;
    g.valid = out_valid;
    g.data  = out_valid ? out_data : 16'h0;
    g.sof   = out_sof;
    g.eof   = out_eof;
    g.tsv   = ts_valid;
    g.ts    = ts_valid ? frame_ts : 16'h0;
    g.ok    = frame_ok;
    g.err   = frame_err;
    g.link  = link_up;
    if (out_valid) vcount++;
    if (frame_ok) okcount++;
    total++;
    if (g !== x) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, g, x);
    end
  endtask

  task automatic word(input logic [15:0] w, input exp_t e);
    drive(w, 2'b11, 2'b00, 1'b0, e);
  endtask

  task automatic partial(input logic [15:0] ts, input logic [15:0] base,
                         input int n);
    word(SW, none());
    word(ts, mk_ts(ts));
    for (int i = 0; i < n; i++) word(16'(base + i), mk_s(i, 16'(base + i)));
  endtask

  task automatic frame(input bit start, input logic [15:0] ts,
                       input logic [15:0] base, input int sidx,
                       input logic [15:0] sval, input logic [15:0] endw);
    logic [15:0] v;
    if (start) word(SW, none());
    word(ts, mk_ts(ts));
    for (int i = 0; i < 125; i++) begin
      v = (i == sidx) ? sval : 16'(base + i);
      word(v, mk_s(i, v));
    end
    word(endw, mk_end(endw == EW));
  endtask

  task automatic force_err();
    word(SW, none());
    drive(16'h0000, 2'b00, 2'b00, 1'b0, mk_end(1'b0));
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{2'b11, 2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{2'b01, 2'b00, 16'hDEAD, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{2'b11, 2'b01, 16'hDEAD, 1'b0, 16'h0000, 1'b0};
    tbl[3]  = '{2'b10, 2'b00, 16'h7FFF, 1'b0, 16'h0000, 1'b0};
    tbl[4]  = '{2'b11, 2'b00, 16'h7FFF, 1'b0, 16'h0000, 1'b0};
    tbl[5]  = '{2'b11, 2'b10, 16'h1234, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{2'b11, 2'b00, 16'hDEAD, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{2'b00, 2'b00, 16'h0055, 1'b0, 16'h0000, 1'b1};
    tbl[8]  = '{2'b11, 2'b00, 16'hDEAD, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{2'b11, 2'b00, 16'h0077, 1'b1, 16'h0077, 1'b0};
    tbl[10] = '{2'b11, 2'b11, 16'h1111, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{2'b11, 2'b00, 16'h2222, 1'b0, 16'h0000, 1'b0};

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sync  = 2'b00;
    datak = 2'b00;
    rxd   = 16'h0;

    tag = "reset";
    repeat (3) drive(16'h0, 2'b11, 2'b00, 1'b1, none());
    check16("rst_data", out_data, 16'h0);
    check16("rst_ts", frame_ts, 16'h0);
    check16("rst_fcnt", frame_count, 16'h0);
    check16("rst_ecnt", err_count, 16'h0);

    tag = "table";
    for (int i = 0; i < 12; i++) begin
      exp_t e = '0;
      e.tsv = tbl[i].tsv;
      e.ts  = tbl[i].ts;
      e.err = tbl[i].err;
      drive(tbl[i].w, tbl[i].sy, tbl[i].dk, 1'b0, e);
    end
    check16("tbl_ecnt", err_count, 16'd2);
    check16("tbl_fcnt", frame_count, 16'd0);
    check16("tbl_ts_hold", frame_ts, 16'h0077);

    tag = "reset2";
    repeat (2) drive(16'h0, 2'b11, 2'b00, 1'b1, none());

    tag = "four_frames";
    vcount  = 0;
    okcount = 0;
    for (int k = 0; k < 4; k++)
      frame(1'b1, 16'(16'h45 + k), 16'(k * 16'h0100), -1, 16'h0, EW);
    check16("ff_valids", 16'(vcount), 16'd500);
    check16("ff_oks", 16'(okcount), 16'd4);
    check16("ff_fcnt", frame_count, 16'd4);
    check16("ff_ecnt", err_count, 16'd0);
    check16("ff_ts", frame_ts, 16'h0048);

    tag = "marker_as_sample";
    frame(1'b1, 16'h50, 16'h1000, 10, SW, EW);
    frame(1'b1, 16'h51, 16'h2000, 30, EW, EW);
    check16("mk_fcnt", frame_count, 16'd6);

    tag = "bad_end";
    frame(1'b1, 16'h60, 16'h3000, -1, 16'h0, 16'h1234);
    check16("be_ecnt", err_count, 16'd1);
    check16("be_fcnt", frame_count, 16'd6);
    frame(1'b1, 16'h61, 16'h3100, -1, 16'h0, EW);
    check16("be_next", frame_count, 16'd7);

    tag = "resync";
    frame(1'b1, 16'h70, 16'h4000, -1, 16'h0, SW);
    frame(1'b0, 16'h99, 16'h4100, -1, 16'h0, EW);
    check16("rs_ecnt", err_count, 16'd2);
    check16("rs_fcnt", frame_count, 16'd8);
    check16("rs_ts", frame_ts, 16'h0099);

    tag = "sync_loss";
    partial(16'h80, 16'h5000, 40);
    drive(16'h5028, 2'b01, 2'b00, 1'b0, mk_end(1'b0));
    drive(SW, 2'b01, 2'b00, 1'b0, none());
    drive(16'h0080, 2'b01, 2'b00, 1'b0, none());
    word(16'h0000, none());
    frame(1'b1, 16'h81, 16'h5100, -1, 16'h0, EW);
    check16("sl_ecnt", err_count, 16'd3);
    check16("sl_fcnt", frame_count, 16'd9);

    tag = "err_sat";
    word(16'h0000, none());
    dut.err_count_q = 16'hFFFD;
    force_err();
    force_err();
    check16("sat_ecnt", err_count, 16'hFFFF);
    force_err();
    force_err();
    check16("sat_ecnt_hold", err_count, 16'hFFFF);

    tag = "frame_sat";
    word(16'h0000, none());
    dut.frame_count_q = 16'hFFFE;
    frame(1'b1, 16'h8A, 16'h6000, -1, 16'h0, EW);
    check16("sat_fcnt", frame_count, 16'hFFFF);
    frame(1'b1, 16'h8B, 16'h6100, -1, 16'h0, EW);
    check16("sat_fcnt_hold", frame_count, 16'hFFFF);

    tag = "mid_reset";
    partial(16'h90, 16'h7000, 60);
    drive(16'h703C, 2'b11, 2'b00, 1'b1, none());
    drive(16'h703D, 2'b11, 2'b00, 1'b1, none());
    check16("mr_data", out_data, 16'h0);
    check16("mr_ts", frame_ts, 16'h0);
    check16("mr_fcnt", frame_count, 16'h0);
    check16("mr_ecnt", err_count, 16'h0);
    tag = "post_reset";
    for (int i = 0; i < 5; i++) word(16'(16'h703E + i), none());
    word(EW, none());
    frame(1'b1, 16'h91, 16'h7100, -1, 16'h0, EW);
    check16("pr_fcnt", frame_count, 16'd1);
    check16("pr_ecnt", err_count, 16'd0);
    check16("pr_ts", frame_ts, 16'h0091);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 Parameter FRAME_LEN, default 128, words per frame including start, timestamp and end words.
REQ-002 Parameter START_WORD, default 16'hDEAD, frame start marker.
REQ-003 Parameter END_WORD, default 16'h7FFF, frame end marker.
REQ-004 rx_std_clkout  in  1  sole clock, recovered transceiver clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_syncstatus  in  2  transceiver word-sync status, one bit per byte lane.
REQ-007 rx_datak  in  2  control-character flags, one bit per byte lane.
REQ-008 RX_data  in  16  received word, one per clock.
REQ-009 out_data  out  16  registered sample word, feeds Thresholder data input.
REQ-010 out_valid  out  1  out_data is a sample word of the current frame.
REQ-011 out_sof / out_eof  out  1 each  first / last sample word of the frame, qualified by out_valid.
REQ-012 frame_ts  out  16  timestamp of the current frame; ts_valid  out  1  one-cycle pulse when frame_ts updates.
REQ-013 frame_ok / frame_err  out  1 each  one-cycle pulse: frame closed correctly / frame aborted.
REQ-014 frame_count, err_count  out  16 each  saturating counters of good and aborted frames.
REQ-015 link_up  out  1  registered link-qualified status.

Function
REQ-016 Link qualified when rx_syncstatus==2'b11 and rx_datak==2'b00; link_up is this condition delayed one cycle.
REQ-017 FSM states: HUNT, TS, DATA, ENDCHK; all input words are evaluated in the cycle they are sampled.
REQ-018 HUNT: word == START_WORD with link qualified -> TS; any other word discarded, no error.
REQ-019 TS: word latched into frame_ts and ts_valid pulses next cycle -> DATA, sample counter cleared.
REQ-020 DATA: each word emitted with out_valid=1 one cycle later; after FRAME_LEN-3 samples (125 by default) -> ENDCHK.
REQ-021 Sample words equal to START_WORD or END_WORD in DATA are ordinary samples, never markers.
REQ-022 out_sof accompanies sample index 0; out_eof accompanies sample index FRAME_LEN-4.
REQ-023 ENDCHK: word == END_WORD -> frame_ok pulse next cycle, frame_count+1, -> HUNT.
REQ-024 ENDCHK: word != END_WORD -> frame_err pulse, err_count+1; if the word equals START_WORD -> TS (resync), else -> HUNT.
REQ-025 Link disqualified in TS, DATA or ENDCHK: frame aborted, frame_err pulse next cycle, err_count+1, -> HUNT; no out_valid for that word.
REQ-026 Link disqualified in HUNT: no error, remain HUNT.
REQ-027 Samples already emitted from an aborted frame are not retracted; consumer discards on frame_err.
REQ-028 Latency input to output: exactly one clock for out_data/out_valid/out_sof/out_eof; frame_ok/frame_err one clock after the deciding word.
REQ-029 frame_count and err_count saturate at 16'hFFFF, never wrap.
REQ-030 frame_ok and frame_err never asserted in the same cycle; out_valid never asserted while in HUNT.
REQ-031 frame_ts holds its value until the next TS word; not cleared by frame_err.

Reset
REQ-032 rst sampled high: FSM -> HUNT, sample counter 0, all outputs 0 including frame_ts, counters and link_up.
REQ-033 rst asserted mid-frame: frame dropped silently, no frame_err pulse, no counter update; first frame after release requires a fresh START_WORD.

Verification
REQ-034 Four back-to-back 128-word frames (DEAD, TS 0x45..0x48, ramp, 7FFF) -> 125 out_valid per frame, frame_ts 0x45..0x48, 4 frame_ok, frame_count=4, err_count=0.
REQ-035 Ramp sample value 16'hDEAD inside DATA -> passed as sample, frame_ok still asserted, no resync.
REQ-036 End word 16'h1234 instead of 7FFF -> frame_err, err_count=1, frame_count unchanged; next DEAD frame accepted.
REQ-037 End position carries 16'hDEAD followed by TS 0x99 and full frame -> frame_err then frame_ok with frame_ts=0x99.
REQ-038 rx_syncstatus drops to 2'b01 at sample 40 -> frame_err one cycle later, out_valid stops, link_up low; recovery on next DEAD after sync returns.
REQ-039 rst pulsed at sample 60, and err_count preloaded to 16'hFFFF by forced errors -> all outputs 0 after reset, no frame_err; separately, further errors leave err_count at 16'hFFFF.
